// File: rtl/aos_sr_app_gate_ctrl.sv
// SoftReg app gate: decodes the target app, gates disabled apps, serialises
// host reads with a timeout and keeps drop/timeout statistics.

package aos_sr_pkg;
  localparam int unsigned SR_ADDR_W = 32;
  localparam int unsigned SR_DATA_W = 64;

  typedef struct packed {
    logic                 valid;
    logic                 is_write;
    logic [SR_ADDR_W-1:0] addr;
    logic [SR_DATA_W-1:0] data;
  } soft_reg_req_t;

  typedef struct packed {
    logic                 valid;
    logic [SR_DATA_W-1:0] data;
  } soft_reg_resp_t;
endpackage

module aos_sr_app_gate_ctrl
  import aos_sr_pkg::*;
#(
  parameter int unsigned          SR_NUM_APPS    = 2,
  parameter int unsigned          FIFO_LOG_DEPTH = 2,
  parameter int unsigned          TIMEOUT_CYCLES = 1024,
  parameter logic [SR_DATA_W-1:0] ERR_DATA       = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           app_enable [SR_NUM_APPS],
  input  soft_reg_req_t  host_sr_req,
  output soft_reg_resp_t host_sr_resp,
  output soft_reg_req_t  tree_sr_req,
  input  soft_reg_resp_t tree_sr_resp,
  output logic           busy,
  output logic [15:0]    timeout_count,
  output logic [15:0]    drop_count
);

  localparam int unsigned ID_BITS = $clog2(SR_NUM_APPS);
  localparam int unsigned ID_W    = (ID_BITS == 0) ? 1 : ID_BITS;
  localparam int unsigned DEPTH   = 1 << FIFO_LOG_DEPTH;
  localparam int unsigned PTR_W   = FIFO_LOG_DEPTH;
  localparam int unsigned CNT_W   = FIFO_LOG_DEPTH + 1;
  localparam int unsigned TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SUM_W   = 18;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  soft_reg_req_t  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic           fifo_empty, fifo_full;
  logic           push, pop;
  soft_reg_req_t  head;
  logic [ID_W-1:0] head_id;
  logic           head_en;

  soft_reg_req_t  tree_req_d;
  soft_reg_resp_t host_resp_d;
  logic           drop_fifo, drop_head, drop_resp, to_inc;
  logic [SUM_W-1:0] drop_sum;

  // Input queue status; overflow discards the incoming request
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign push       = host_sr_req.valid && !fifo_full;
  assign drop_fifo  = host_sr_req.valid && fifo_full;
  assign head       = mem[rd_ptr_q];
  assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

  // App id decode from the low address bits of the queue head
  generate
    if (ID_BITS == 0) begin : g_single_app
      assign head_id = '0;
    end else begin : g_multi_app
      assign head_id = head.addr[ID_BITS-1:0];
    end
  endgenerate

  // Ids beyond the app count never match and read as disabled
  always_comb begin
    head_en = 1'b0;
    for (int unsigned i = 0; i < SR_NUM_APPS; i++) begin
      if (head_id == ID_W'(i)) head_en = app_enable[i];
    end
  end

  // Queue storage, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= host_sr_req;
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next state, head dispatch and response selection
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pop         = 1'b0;
    tree_req_d  = '0;
    host_resp_d = '0;
    drop_head   = 1'b0;
    drop_resp   = 1'b0;
    to_inc      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tree_sr_resp.valid) drop_resp = 1'b1;
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.is_write) begin
            if (head_en) tree_req_d = head;
            else         drop_head  = 1'b1;
          end else if (head_en) begin
            tree_req_d = head;
            timer_d    = TMR_W'(TIMEOUT_CYCLES);
            state_d    = ST_WAIT;
          end else begin
            host_resp_d.valid = 1'b1;
            host_resp_d.data  = ERR_DATA;
          end
        end
      end
      ST_WAIT: begin
        if (tree_sr_resp.valid) begin
          host_resp_d = tree_sr_resp;
          state_d     = ST_IDLE;
        end else if (timer_q == TMR_W'(1)) begin
          host_resp_d.valid = 1'b1;
          host_resp_d.data  = ERR_DATA;
          to_inc            = 1'b1;
          state_d           = ST_IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
        // Writes keep flowing while a read is outstanding; reads stall the queue
        if (!fifo_empty && head.is_write) begin
          pop = 1'b1;
          if (head_en) tree_req_d = head;
          else         drop_head  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Up to three drop sources can fire in one cycle
  assign drop_sum = SUM_W'(drop_count) + SUM_W'(drop_fifo) + SUM_W'(drop_head)
                  + SUM_W'(drop_resp);

  // Registered outputs and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      host_sr_resp  <= '0;
      tree_sr_req   <= '0;
      timeout_count <= '0;
      drop_count    <= '0;
    end else begin
      host_sr_resp <= host_resp_d;
      tree_sr_req  <= tree_req_d;
      if (to_inc && (timeout_count != 16'hFFFF)) timeout_count <= timeout_count + 16'd1;
      drop_count <= (drop_sum > SUM_W'(16'hFFFF)) ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign busy = (state_q == ST_WAIT);

endmodule

// File: tb/tb_aos_sr_app_gate_ctrl.sv
// Bench for aos_sr_app_gate_ctrl: table of single transactions plus
// hand-written read/timeout/ordering/overflow/reset sequences.

module tb_aos_sr_app_gate_ctrl;
  import aos_sr_pkg::*;

  localparam int unsigned NAPPS = 4;
  localparam int unsigned TO    = 12;
  localparam logic [63:0] ERR   = 64'hDEAD_BEEF_DEAD_BEEF;

  localparam int K_TW   = 0;
  localparam int K_TR   = 1;
  localparam int K_ERR  = 2;
  localparam int K_DROP = 3;

  typedef struct {
    int           cyc;
    logic [127:0] val;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [63:0] data;
    logic [3:0]  en;
    int          kind;
    logic [63:0] rdata;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           app_enable [NAPPS];
  soft_reg_req_t  host_sr_req;
  soft_reg_resp_t host_sr_resp;
  soft_reg_req_t  tree_sr_req;
  soft_reg_resp_t tree_sr_resp;
  logic           busy;
  logic [15:0]    timeout_count;
  logic [15:0]    drop_count;

  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   exp_drop = 0;
  exp_t tree_q[$];
  exp_t host_q[$];
  vec_t vecs[9];

  aos_sr_app_gate_ctrl #(
    .SR_NUM_APPS(NAPPS),
    .FIFO_LOG_DEPTH(2),
    .TIMEOUT_CYCLES(TO),
    .ERR_DATA(ERR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .app_enable(app_enable),
    .host_sr_req(host_sr_req),
    .host_sr_resp(host_sr_resp),
    .tree_sr_req(tree_sr_req),
    .tree_sr_resp(tree_sr_resp),
    .busy(busy),
    .timeout_count(timeout_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [63:0] d);
    host_sr_req = '{valid: 1'b1, is_write: w, addr: a, data: d};
    step(1);
    host_sr_req = '0;
  endtask

  function automatic logic [127:0] treev(input logic w, input logic [31:0] a, input logic [63:0] d);
    return {31'd0, 1'b1, w, a, d};
  endfunction

  function automatic logic [127:0] hostv(input logic [63:0] d);
    return {63'd0, 1'b1, d};
  endfunction

  task automatic set_en(input logic [3:0] en);
    for (int j = 0; j < 4; j++) app_enable[j] = en[j];
  endtask

  // Scoreboard: every output beat is matched against the head of its queue
  always @(negedge clk) begin
    exp_t e;
    if (tree_sr_req.valid) begin
      if (tree_q.size() == 0) begin
        chk("tree_unexpected", treev(tree_sr_req.is_write, tree_sr_req.addr, tree_sr_req.data), 128'd0);
      end else begin
        e = tree_q.pop_front();
        chk("tree_req", treev(tree_sr_req.is_write, tree_sr_req.addr, tree_sr_req.data), e.val);
        chk("tree_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
    if (host_sr_resp.valid) begin
      if (host_q.size() == 0) begin
        chk("host_unexpected", hostv(host_sr_resp.data), 128'd0);
      end else begin
        e = host_q.pop_front();
        chk("host_resp", hostv(host_sr_resp.data), e.val);
        chk("host_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int r;
    vec_t v;

    vecs[0] = '{1'b1, 32'h0000_0042, 64'd5,           4'b1111, K_TW,   64'd0};
    vecs[1] = '{1'b1, 32'h0000_0043, 64'd7,           4'b1111, K_TW,   64'd0};
    vecs[2] = '{1'b0, 32'h0000_0041, 64'd0,           4'b1111, K_TR,   64'h1234};
    vecs[3] = '{1'b0, 32'h0000_0003, 64'd0,           4'b0111, K_ERR,  64'd0};
    vecs[4] = '{1'b1, 32'h0000_0003, 64'd9,           4'b0111, K_DROP, 64'd0};
    vecs[5] = '{1'b1, 32'h0000_0100, 64'd11,          4'b1110, K_DROP, 64'd0};
    vecs[6] = '{1'b0, 32'h0000_0102, 64'd0,           4'b1011, K_ERR,  64'd0};
    vecs[7] = '{1'b1, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1111, K_TW, 64'd0};
    vecs[8] = '{1'b0, 32'h0000_0000, 64'd0,           4'b0001, K_TR,   64'hCAFE};

    rst          = 1'b1;
    host_sr_req  = '0;
    tree_sr_resp = '0;
    set_en(4'b1111);
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_host_valid", 128'(host_sr_resp.valid), 128'd0);
    chk("rst_tree_valid", 128'(tree_sr_req.valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_timeout_count", 128'(timeout_count), 128'd0);
    chk("rst_drop_count", 128'(drop_count), 128'd0);

    // Single transactions from an idle controller with an empty queue
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      set_en(v.en);
      k = cyc;
      case (v.kind)
        K_TW, K_TR: tree_q.push_back('{k + 2, treev(v.w, v.addr, v.data)});
        K_ERR:      host_q.push_back('{k + 2, hostv(ERR)});
        default:    exp_drop++;
      endcase
      send(v.w, v.addr, v.data);
      step(2);
      if (v.kind == K_TR) begin
        chk("vec_busy_wait", 128'(busy), 128'd1);
        tree_sr_resp = '{valid: 1'b1, data: v.rdata};
        host_q.push_back('{cyc + 1, hostv(v.rdata)});
        step(1);
        tree_sr_resp = '0;
      end
      step(1);
      chk("vec_drop_count", 128'(drop_count), 128'(exp_drop));
      chk("vec_busy_idle", 128'(busy), 128'd0);
    end
    set_en(4'b1111);

    // Read id 1 answered after 10 waiting cycles
    k = cyc;
    tree_q.push_back('{k + 2, treev(1'b0, 32'h1, 64'd0)});
    send(1'b0, 32'h1, 64'd0);
    step(1);
    for (int i = 0; i < 10; i++) begin
      chk("read_busy", 128'(busy), 128'd1);
      step(1);
    end
    tree_sr_resp = '{valid: 1'b1, data: 64'h1234};
    host_q.push_back('{cyc + 1, hostv(64'h1234)});
    step(1);
    tree_sr_resp = '0;
    chk("read_busy_done", 128'(busy), 128'd0);
    step(2);

    // Read id 0 never answered: error after TO waiting cycles, late reply dropped
    k = cyc;
    tree_q.push_back('{k + 2, treev(1'b0, 32'h0, 64'd0)});
    host_q.push_back('{k + 2 + int'(TO), hostv(ERR)});
    send(1'b0, 32'h0, 64'd0);
    step(int'(TO) + 2);
    chk("to_count", 128'(timeout_count), 128'd1);
    chk("to_busy", 128'(busy), 128'd0);
    tree_sr_resp = '{valid: 1'b1, data: 64'h5555};
    exp_drop++;
    step(1);
    tree_sr_resp = '0;
    step(1);
    chk("late_drop_count", 128'(drop_count), 128'(exp_drop));

    // Response in the expiry cycle wins over the timeout
    k = cyc;
    tree_q.push_back('{k + 2, treev(1'b0, 32'h2, 64'd0)});
    send(1'b0, 32'h2, 64'd0);
    step(int'(TO));
    tree_sr_resp = '{valid: 1'b1, data: 64'h7777};
    host_q.push_back('{cyc + 1, hostv(64'h7777)});
    step(1);
    tree_sr_resp = '0;
    step(2);
    chk("expiry_to_count", 128'(timeout_count), 128'd1);

    // Ordering: a write passes a waiting read, but a queued read holds what follows
    k = cyc;
    tree_q.push_back('{k + 2, treev(1'b0, 32'h0, 64'd0)});
    send(1'b0, 32'h0, 64'd0);
    tree_q.push_back('{k + 3, treev(1'b1, 32'h5, 64'hAA)});
    send(1'b1, 32'h5, 64'hAA);
    send(1'b0, 32'h6, 64'd0);
    send(1'b1, 32'h9, 64'hBB);
    step(5);
    chk("order_busy_hold", 128'(busy), 128'd1);
    r = cyc;
    tree_sr_resp = '{valid: 1'b1, data: 64'h100};
    host_q.push_back('{r + 1, hostv(64'h100)});
    tree_q.push_back('{r + 2, treev(1'b0, 32'h6, 64'd0)});
    tree_q.push_back('{r + 3, treev(1'b1, 32'h9, 64'hBB)});
    step(1);
    tree_sr_resp = '0;
    step(2);
    chk("order_busy_second", 128'(busy), 128'd1);
    tree_sr_resp = '{valid: 1'b1, data: 64'h200};
    host_q.push_back('{cyc + 1, hostv(64'h200)});
    step(1);
    tree_sr_resp = '0;
    step(2);

    // Queue overflow while a read waits, then reset mid-read
    k = cyc;
    tree_q.push_back('{k + 2, treev(1'b0, 32'h0, 64'd0)});
    send(1'b0, 32'h0, 64'd0);
    step(1);
    for (int i = 0; i < 6; i++) send(1'b0, 32'(i + 1), 64'd0);
    exp_drop += 2;
    step(1);
    chk("ovf_drop_count", 128'(drop_count), 128'(exp_drop));
    chk("ovf_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_drop = 0;
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_drop", 128'(drop_count), 128'd0);
    chk("mid_rst_timeout", 128'(timeout_count), 128'd0);
    chk("mid_rst_tree_valid", 128'(tree_sr_req.valid), 128'd0);
    step(int'(TO) + 4);
    k = cyc;
    tree_q.push_back('{k + 2, treev(1'b1, 32'h42, 64'd5)});
    send(1'b1, 32'h42, 64'd5);
    step(4);
    chk("post_rst_busy", 128'(busy), 128'd0);

    chk("tree_q_left", 128'(tree_q.size()), 128'd0);
    chk("host_q_left", 128'(host_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
